// File: rtl/if_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl_pkg
// Shared definitions for the fetch-stage sequencer: default reset PC,
// fetch FSM state encoding and the sequential next-PC helper.
// ---------------------------------------------------------------------------
package if_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'hBFC0_0000;
  localparam int          FETCH_STATE_LENGTH = 2;

  typedef enum logic [FETCH_STATE_LENGTH-1:0] {
    FETCH_IDLE = 2'd0,  // one cycle after reset release
    FETCH_REQ  = 2'd1,  // request outstanding at fetch_pc
    FETCH_HOLD = 2'd2,  // skid full, no request
    FETCH_KILL = 2'd3   // flushed request still on the bus, response dropped
  } fetch_state_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_skid.sv
// ---------------------------------------------------------------------------
// if_skid_buf
// One-entry pc/inst holding register used when an instruction returns from
// memory while ID is stalled.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   clear                 empty the buffer (highest priority)
//   load, load_pc/inst    capture an instruction, buffer becomes full
//   unload                buffer handed its content on, becomes empty
//   full, pc, inst        buffer state and content
// ---------------------------------------------------------------------------
module if_skid_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  input  logic        unload,
  output logic        full,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full <= 1'b0;
      pc   <= 32'd0;
      inst <= 32'd0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      pc   <= load_pc;
      inst <= load_inst;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
// Fetch-stage sequencer. Owns the fetch PC, keeps at most one instruction
// request outstanding, delivers instructions to ID through an output register
// backed by a one-entry skid, applies branch redirects after the delay slot
// and applies exception/eret flushes immediately.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   redirect_valid/redirect_pc   taken branch/jump resolved in ID (pulse)
//   flush_valid/flush_pc         exception/eret flush (pulse), wins over redirect
//   id_ready                     ID accepts if_* this cycle
//   inst_req/inst_addr           instruction memory request
//   inst_ack/inst_rdata          request completion and returned instruction
//   fetch_pc                     current fetch PC register
//   if_valid/if_pc/if_inst       instruction presented to ID
// ---------------------------------------------------------------------------
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  input  logic        id_ready,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] fetch_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0] fetch_pc_next;
  logic [31:0] kill_addr;
  logic        pend_valid;
  logic [31:0] pend_pc;

  logic        skid_full;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;

  logic slot_free;
  logic ack_req;
  logic redirect_take;
  logic deliver;
  logic skid_load;
  logic skid_unload;

  assign slot_free     = !if_valid || id_ready;
  assign ack_req       = (state == FETCH_REQ) && inst_ack;
  // A branch sitting in a delay slot (pend already set) cannot redirect again.
  assign redirect_take = redirect_valid && !flush_valid && !pend_valid;
  assign deliver       = ack_req && slot_free && !flush_valid;
  assign skid_load     = ack_req && !slot_free && !flush_valid;
  assign skid_unload   = (state == FETCH_HOLD) && skid_full && id_ready && !flush_valid;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= FETCH_IDLE;
    else         state <= state_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: state_next = FETCH_REQ;
      FETCH_REQ: begin
        if (flush_valid)   state_next = inst_ack ? FETCH_REQ : FETCH_KILL;
        else if (inst_ack) state_next = slot_free ? FETCH_REQ : FETCH_HOLD;
      end
      FETCH_HOLD: begin
        if (flush_valid || id_ready) state_next = FETCH_REQ;
      end
      FETCH_KILL: begin
        if (inst_ack) state_next = FETCH_REQ;
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. KILL keeps the flushed address on the bus until its ack.
  // -------------------------------------------------------------------------
  always_comb begin
    inst_req  = 1'b0;
    inst_addr = fetch_pc;
    case (state)
      FETCH_REQ:  inst_req = 1'b1;
      FETCH_KILL: begin
        inst_req  = 1'b1;
        inst_addr = kill_addr;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Fetch PC update. In REQ fetch_pc only moves on ack, which keeps the bus
  // address stable while the request is outstanding; a redirect arriving
  // before the delay slot returns is parked in pend_pc.
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_pc_next = fetch_pc;
    if (flush_valid) begin
      fetch_pc_next = flush_pc;
    end else if (ack_req) begin
      if (pend_valid)         fetch_pc_next = pend_pc;
      else if (redirect_take) fetch_pc_next = redirect_pc;
      else                    fetch_pc_next = seq_pc(fetch_pc);
    end else if ((state == FETCH_HOLD) && redirect_take) begin
      // Delay slot already captured in the skid.
      fetch_pc_next = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc   <= RESET_PC;
      kill_addr  <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'd0;
    end else begin
      fetch_pc <= fetch_pc_next;
      if ((state == FETCH_REQ) && flush_valid && !inst_ack) kill_addr <= fetch_pc;
      if (flush_valid || ack_req) begin
        pend_valid <= 1'b0;
      end else if ((state == FETCH_REQ) && redirect_take) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register towards ID
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_valid <= 1'b0;
      if_pc    <= 32'd0;
      if_inst  <= 32'd0;
    end else if (flush_valid) begin
      if_valid <= 1'b0;
    end else if (deliver) begin
      if_valid <= 1'b1;
      if_pc    <= fetch_pc;
      if_inst  <= inst_rdata;
    end else if (skid_unload) begin
      if_valid <= 1'b1;
      if_pc    <= skid_pc;
      if_inst  <= skid_inst;
    end else if (id_ready) begin
      if_valid <= 1'b0;
    end
  end

  if_skid_buf u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (flush_valid),
    .load      (skid_load),
    .load_pc   (fetch_pc),
    .load_inst (inst_rdata),
    .unload    (skid_unload),
    .full      (skid_full),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
// Drives the fetch sequencer with a randomized memory and ID stage and
// compares the delivered instruction stream with an architectural model
// (program order with delay slots and flushes).
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        id_ready;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] fetch_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .id_ready       (id_ready),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_ack       (inst_ack),
    .inst_rdata     (inst_rdata),
    .fetch_pc       (fetch_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  int errors = 0;
  int checks = 0;

  // Architectural model: the next PC ID should see, plus a pending branch target
  // that takes effect after the delay slot.
  logic [31:0] exp_pc = 32'hBFC0_0000;
  bit          ds_pending = 1'b0;
  logic [31:0] ds_target = 32'd0;
  int          n_delivered = 0;

  // Bus observation from the previous cycle.
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  bit          prev_flush = 1'b0;
  logic [31:0] prev_flush_pc = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    t = $urandom();
    t[1:0] = 2'b00;
    if ($urandom_range(3) == 0) t = 32'hFFFF_FFF8;  // exercises wrap to 0
    return t;
  endfunction

  function automatic logic [31:0] pick_flush();
    logic [31:0] t;
    case ($urandom_range(2))
      0:       t = 32'hBFC0_0380;
      1:       t = 32'h8000_0180;
      default: begin
        t = $urandom();
        t[1:0] = 2'b00;
      end
    endcase
    return t;
  endfunction

  // Called just after a falling edge: check what the last rising edge produced,
  // then drive inputs for the next rising edge.
  task automatic step(input int ack_pct, input int ready_pct, input int branch_pct,
                      input int flush_pct);
    bit accept;
    if (prev_req && !prev_ack) begin
      check("bus_req_held", 32'(inst_req), 32'd1);
      check("bus_addr_stable", inst_addr, prev_addr);
    end
    if (prev_flush) begin
      check("flush_if_valid", 32'(if_valid), 32'd0);
      check("flush_fetch_pc", fetch_pc, prev_flush_pc);
    end

    redirect_valid = 1'b0;
    flush_valid    = 1'b0;
    id_ready       = (int'($urandom_range(99)) < ready_pct);
    accept         = if_valid && id_ready;
    if (accept) begin
      check("deliver_pc", if_pc, exp_pc);
      check("deliver_inst", if_inst, mem_word(if_pc));
      $display("deliver #%0d pc=%08h inst=%08h", n_delivered, if_pc, if_inst);
      n_delivered++;
      if (ds_pending) begin
        exp_pc     = ds_target;
        ds_pending = 1'b0;
      end else if (int'($urandom_range(99)) < branch_pct) begin
        redirect_valid = 1'b1;
        redirect_pc    = pick_target();
        ds_pending     = 1'b1;
        ds_target      = redirect_pc;
        exp_pc         = exp_pc + 32'd4;
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (int'($urandom_range(99)) < flush_pct) begin
      flush_valid = 1'b1;
      flush_pc    = pick_flush();
      exp_pc      = flush_pc;
      ds_pending  = 1'b0;
    end

    inst_ack   = inst_req && (int'($urandom_range(99)) < ack_pct);
    inst_rdata = inst_ack ? mem_word(inst_addr) : $urandom();

    prev_req      = inst_req;
    prev_ack      = inst_ack;
    prev_addr     = inst_addr;
    prev_flush    = flush_valid;
    prev_flush_pc = flush_pc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_req"}, 32'(inst_req), 32'd0);
    check({tag, "_inst_addr"}, inst_addr, 32'hBFC0_0000);
    check({tag, "_fetch_pc"}, fetch_pc, 32'hBFC0_0000);
    check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check({tag, "_if_inst"}, if_inst, 32'd0);
  endtask

  initial begin
    bit found;
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    flush_valid    = 1'b0;
    flush_pc       = 32'd0;
    id_ready       = 1'b0;
    inst_ack       = 1'b0;
    inst_rdata     = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Back-to-back fetch with an always-ready memory and ID.
    @(negedge clk);
    check("first_req", 32'(inst_req), 32'd1);
    check("addr_0", inst_addr, 32'hBFC0_0000);
    step(100, 100, 0, 0);
    @(negedge clk);
    check("addr_1", inst_addr, 32'hBFC0_0004);
    check("valid_2nd_cycle", 32'(if_valid), 32'd1);
    step(100, 100, 0, 0);
    @(negedge clk);
    check("addr_2", inst_addr, 32'hBFC0_0008);

    // Stall ID: the next return lands in the skid and requests stop.
    step(100, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_no_req", 32'(inst_req), 32'd0);
      step(100, 0, 0, 0);
    end
    @(negedge clk);
    step(100, 100, 0, 0);
    @(negedge clk);
    check("resume_addr", inst_addr, 32'hBFC0_000C);
    step(100, 100, 0, 0);

    // Randomized phases with varying memory latency, ID stalls, branches, flushes.
    repeat (500)  begin @(negedge clk); step(100, 100, 15, 0); end
    repeat (1000) begin @(negedge clk); step(60, 70, 15, 2);   end
    repeat (1000) begin @(negedge clk); step(40, 40, 20, 4);   end
    repeat (800)  begin @(negedge clk); step(100, 30, 25, 3);  end

    check("liveness", 32'(n_delivered > 300), 32'd1);

    // Reset asserted while a request is outstanding.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (inst_req) found = 1'b1;
      else          step(0, 100, 0, 0);
    end
    check("mid_req_seen", 32'(inst_req), 32'd1);
    redirect_valid = 1'b0;
    flush_valid    = 1'b0;
    inst_ack       = 1'b0;
    resetn         = 1'b0;
    #1;
    check_reset_outputs("async_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
